// File: rtl/mult_share_pkg.sv
// Shared types and default sizing for the time-shared multiplier scheduler.
package mult_share_pkg;

  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_MULT_LAT = 2;

  localparam int CH_W   = $clog2(DEF_NUM_CH);
  localparam int PROD_W = 2 * DEF_DATA_W;

  typedef struct packed {
    logic              valid;
    logic [CH_W-1:0]   tag;
    logic [PROD_W-1:0] product;
  } stage_t;

endpackage

// File: rtl/mult_share_sched_arbiter.sv
// Combinational round-robin picker: first requesting channel at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         req_valid,
  input  logic                      enable,
  input  logic [$clog2(NUM_CH)-1:0] ptr,
  output logic [NUM_CH-1:0]         grant,
  output logic [$clog2(NUM_CH)-1:0] grant_idx,
  output logic                      grant_any
);

  localparam int IDX_W = $clog2(NUM_CH);

  logic [IDX_W-1:0] cand;

  // Scan farthest offset first so the nearest requester overwrites and wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      cand = ptr + IDX_W'(i);
      if (enable && req_valid[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        grant_idx   = cand;
        grant_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_share_sched.sv
// One signed multiplier shared round-robin among NUM_CH requesters; products return tagged per channel.
module mult_share_sched
  import mult_share_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MULT_LAT = DEF_MULT_LAT
) (
  input  logic                         Ex_Clock,
  input  logic                         Ex_Rst_n,
  input  logic                         Sched_En,
  input  logic [NUM_CH-1:0]            Req_Valid,
  output logic [NUM_CH-1:0]            Req_Ready,
  input  logic [NUM_CH*DATA_W-1:0]     Req_A,
  input  logic [NUM_CH*DATA_W-1:0]     Req_B,
  output logic [NUM_CH-1:0]            Res_Valid,
  output logic [NUM_CH*2*DATA_W-1:0]   Res_Data,
  output logic                         Idle
);

  localparam int TAG_W = $clog2(NUM_CH);
  localparam int RES_W = 2 * DATA_W;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [RES_W-1:0] product;
  } pipe_t;

  logic [TAG_W-1:0]         rr_ptr;
  logic [TAG_W-1:0]         grant_idx;
  logic [NUM_CH-1:0]        grant;
  logic                     grant_any;
  logic                     iss_valid;
  logic [TAG_W-1:0]         iss_tag;
  logic signed [DATA_W-1:0] iss_a;
  logic signed [DATA_W-1:0] iss_b;
  logic [MULT_LAT-1:0]      stage_valid;
  pipe_t                    tail;
  logic [RES_W-1:0]         res_data [NUM_CH];

  // Gating with reset keeps Req_Ready and Idle at 0 while reset is asserted.
  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req_valid (Req_Valid),
    .enable    (Sched_En & Ex_Rst_n),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign Req_Ready = grant;

  always_ff @(posedge Ex_Clock or negedge Ex_Rst_n) begin
    if (!Ex_Rst_n) begin
      rr_ptr    <= '0;
      iss_valid <= 1'b0;
      iss_tag   <= '0;
      iss_a     <= '0;
      iss_b     <= '0;
    end else begin
      iss_valid <= grant_any;
      iss_tag   <= grant_idx;
      iss_a     <= Req_A[grant_idx*DATA_W +: DATA_W];
      iss_b     <= Req_B[grant_idx*DATA_W +: DATA_W];
      if (grant_any) begin
        rr_ptr <= grant_idx + TAG_W'(1);
      end
    end
  end

  for (genvar gi = 0; gi < MULT_LAT; gi++) begin : g_pipe
    pipe_t stage;
    pipe_t stage_in;
    if (gi == 0) begin : g_head
      // Operands are widened before multiplying so the product keeps all 2*DATA_W bits.
      assign stage_in = '{valid:   iss_valid,
                          tag:     iss_tag,
                          product: RES_W'(iss_a) * RES_W'(iss_b)};
    end else begin : g_body
      assign stage_in = g_pipe[gi-1].stage;
    end
    always_ff @(posedge Ex_Clock or negedge Ex_Rst_n) begin
      if (!Ex_Rst_n) begin
        stage <= '0;
      end else begin
        stage <= stage_in;
      end
    end
    assign stage_valid[gi] = stage.valid;
  end

  assign tail = g_pipe[MULT_LAT-1].stage;

  always_ff @(posedge Ex_Clock or negedge Ex_Rst_n) begin
    if (!Ex_Rst_n) begin
      Res_Valid <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        res_data[k] <= '0;
      end
    end else begin
      Res_Valid <= '0;
      if (tail.valid) begin
        Res_Valid[tail.tag] <= 1'b1;
        res_data[tail.tag]  <= tail.product;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_res
    assign Res_Data[gi*RES_W +: RES_W] = res_data[gi];
  end

  assign Idle = Ex_Rst_n & ~iss_valid & ~(|stage_valid) & ~grant_any;

endmodule

// File: tb/tb_mult_share_sched.sv
// Self-checking bench: directed vector table, reset corner sequence, then random traffic vs a queue model.
module tb_mult_share_sched;

  localparam int NUM_CH   = 4;
  localparam int DATA_W   = 8;
  localparam int MULT_LAT = 2;
  localparam int PROD_W   = 2 * DATA_W;

  logic                       Ex_Clock = 1'b0;
  logic                       Ex_Rst_n = 1'b0;
  logic                       Sched_En = 1'b0;
  logic [NUM_CH-1:0]          Req_Valid = '0;
  logic [NUM_CH-1:0]          Req_Ready;
  logic [NUM_CH*DATA_W-1:0]   Req_A = '0;
  logic [NUM_CH*DATA_W-1:0]   Req_B = '0;
  logic [NUM_CH-1:0]          Res_Valid;
  logic [NUM_CH*PROD_W-1:0]   Res_Data;
  logic                       Idle;

  always #5 Ex_Clock = ~Ex_Clock;

  mult_share_sched #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .MULT_LAT(MULT_LAT)) dut (
    .Ex_Clock  (Ex_Clock),
    .Ex_Rst_n  (Ex_Rst_n),
    .Sched_En  (Sched_En),
    .Req_Valid (Req_Valid),
    .Req_Ready (Req_Ready),
    .Req_A     (Req_A),
    .Req_B     (Req_B),
    .Res_Valid (Res_Valid),
    .Res_Data  (Res_Data),
    .Idle      (Idle)
  );

  typedef struct {
    logic              en;
    logic [NUM_CH-1:0] valid;
    int                mode;
    logic [NUM_CH-1:0] exp_ready;
  } vec_t;

  typedef struct {
    int ch;
    int prod;
    int due;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   model_ptr = 0;
  int   model_data [NUM_CH];
  int   waits [NUM_CH];
  int   max_wait = 0;
  int   last_g = -1;
  logic [NUM_CH-1:0] pend = '0;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int model_grant();
    if (!Sched_En) return -1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (Req_Valid[(model_ptr + i) % NUM_CH]) return (model_ptr + i) % NUM_CH;
    end
    return -1;
  endfunction

  task automatic model_reset();
    sbq.delete();
    model_ptr = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      model_data[k] = 0;
      waits[k] = 0;
    end
  endtask

  task automatic set_ops(input int mode);
    for (int k = 0; k < NUM_CH; k++) begin
      if (mode == 0) begin
        Req_A[k*DATA_W +: DATA_W] = DATA_W'(k + 1);
        Req_B[k*DATA_W +: DATA_W] = DATA_W'(-(k + 1));
      end else begin
        Req_A[k*DATA_W +: DATA_W] = DATA_W'(-128);
        Req_B[k*DATA_W +: DATA_W] = DATA_W'(-128);
      end
    end
  endtask

  // One clock cycle: compare outputs mid-cycle, then advance the model across the edge.
  task automatic step(input bit use_tbl, input logic [NUM_CH-1:0] tbl_ready);
    int g;
    logic [NUM_CH-1:0] mg;
    logic [NUM_CH-1:0] ev;
    logic [NUM_CH*PROD_W-1:0] ed;
    bit busy;
    @(negedge Ex_Clock);
    g = model_grant();
    mg = '0;
    if (g >= 0) mg[g] = 1'b1;
    ev = '0;
    busy = 1'b0;
    foreach (sbq[i]) begin
      if (sbq[i].due == cyc) begin
        ev[sbq[i].ch] = 1'b1;
        model_data[sbq[i].ch] = sbq[i].prod;
      end else if (sbq[i].due > cyc) begin
        busy = 1'b1;
      end
    end
    while (sbq.size() > 0 && sbq[0].due <= cyc) void'(sbq.pop_front());
    for (int k = 0; k < NUM_CH; k++) ed[k*PROD_W +: PROD_W] = PROD_W'(model_data[k]);
    check("ready_model", Req_Ready, mg);
    if (use_tbl) check("ready_table", Req_Ready, tbl_ready);
    check("res_valid", Res_Valid, ev);
    check("res_data", Res_Data, ed);
    check("idle", Idle, (!busy && g < 0));
    if (g >= 0) begin
      int pa;
      int pb;
      pa = $signed(Req_A[g*DATA_W +: DATA_W]);
      pb = $signed(Req_B[g*DATA_W +: DATA_W]);
      sbq.push_back('{g, pa * pb, cyc + MULT_LAT + 2});
      model_ptr = (g + 1) % NUM_CH;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (Req_Valid[k] && k != g) waits[k]++;
      else waits[k] = 0;
      if (waits[k] > max_wait) max_wait = waits[k];
    end
    last_g = g;
    @(posedge Ex_Clock);
    cyc++;
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, Req_Ready, 0);
    check({tag, "_valid"}, Res_Valid, 0);
    check({tag, "_data"}, Res_Data, 0);
    check({tag, "_idle"}, Idle, 0);
  endtask

  task automatic add(input logic en, input logic [NUM_CH-1:0] v, input int mode,
                     input logic [NUM_CH-1:0] r, input int n);
    for (int i = 0; i < n; i++) vecs.push_back('{en, v, mode, r});
  endtask

  initial begin
    model_reset();
    // all channels continuous: grants 0,1,2,3,0
    add(1'b1, 4'b1111, 0, 4'b0001, 1);
    add(1'b1, 4'b1111, 0, 4'b0010, 1);
    add(1'b1, 4'b1111, 0, 4'b0100, 1);
    add(1'b1, 4'b1111, 0, 4'b1000, 1);
    add(1'b1, 4'b1111, 0, 4'b0001, 1);
    add(1'b1, 4'b0000, 0, 4'b0000, 4);
    // ch2 alone with -128*-128 every cycle
    add(1'b1, 4'b0100, 1, 4'b0100, 5);
    add(1'b1, 4'b0000, 1, 4'b0000, 4);
    // pointer at 3: ch3 then ch0, then ch1 wins from pointer 1
    add(1'b1, 4'b1001, 0, 4'b1000, 1);
    add(1'b1, 4'b0001, 0, 4'b0001, 1);
    add(1'b1, 4'b0011, 0, 4'b0010, 1);
    add(1'b1, 4'b0000, 0, 4'b0000, 1);
    // one grant, then scheduling disabled while everyone requests
    add(1'b1, 4'b1111, 0, 4'b0100, 1);
    add(1'b0, 4'b1111, 0, 4'b0000, 5);
    add(1'b1, 4'b0000, 0, 4'b0000, 4);

    Sched_En  = 1'b1;
    Req_Valid = '1;
    repeat (3) @(posedge Ex_Clock);
    #1;
    check_zero("por");
    Req_Valid = '0;
    @(negedge Ex_Clock);
    #1 Ex_Rst_n = 1'b1;
    @(posedge Ex_Clock);
    #1;

    foreach (vecs[i]) begin
      Sched_En  = vecs[i].en;
      Req_Valid = vecs[i].valid;
      set_ops(vecs[i].mode);
      step(1'b1, vecs[i].exp_ready);
    end

    // reset with two ops in flight
    Sched_En  = 1'b1;
    Req_Valid = '1;
    set_ops(0);
    step(1'b0, '0);
    step(1'b0, '0);
    #2 Ex_Rst_n = 1'b0;
    #1 check_zero("arst");
    @(negedge Ex_Clock);
    check_zero("rst_hold");
    Req_Valid = '0;
    model_reset();
    #1 Ex_Rst_n = 1'b1;
    @(posedge Ex_Clock);
    #1;
    for (int i = 0; i < 5; i++) step(1'b1, 4'b0000);
    Req_Valid = '1;
    step(1'b1, 4'b0001);
    Req_Valid = '0;
    for (int i = 0; i < 5; i++) step(1'b1, 4'b0000);

    // random traffic obeying the hold-until-granted rule
    for (int k = 0; k < NUM_CH; k++) waits[k] = 0;
    max_wait = 0;
    last_g = -1;
    pend = '0;
    Sched_En = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (k == last_g) pend[k] = 1'b0;
        if (!pend[k] && $urandom_range(0, 1) == 1) begin
          pend[k] = 1'b1;
          Req_A[k*DATA_W +: DATA_W] = ($urandom_range(0, 7) == 0) ? DATA_W'(-128) : DATA_W'($urandom);
          Req_B[k*DATA_W +: DATA_W] = ($urandom_range(0, 7) == 0) ? DATA_W'(-128) : DATA_W'($urandom);
        end
      end
      Req_Valid = pend;
      step(1'b0, '0);
    end
    Req_Valid = '0;
    for (int i = 0; i < MULT_LAT + 3; i++) step(1'b0, '0);

    total++;
    if (max_wait > NUM_CH - 1) begin
      bad++;
      $display("FAIL starvation: got max wait %0d want <= %0d", max_wait, NUM_CH - 1);
    end
    check("scoreboard_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
